// File: rtl/fp_mult2_if.sv
// Host-side bus for the fp_mult2 co-processor: shared operand bus, start request,
// result bus and completion pulse.
interface fp_mult2_if;
    logic [31:0] inBus;
    logic        startFP;
    logic [31:0] resBus;
    logic        doneFP;

    modport master (output inBus, output startFP, input resBus, input doneFP);
    modport slave  (input inBus, input startFP, output resBus, output doneFP);
endinterface

// File: rtl/fp_mult2.sv
// IEEE-754 single-precision multiplier: operands arrive serially on one bus, mantissas
// are multiplied by a 24-step shift-add loop, then normalized, rounded (RNE) and packed.
module fp_mult2 (
    input  logic        clk,
    input  logic        rst,
    fp_mult2_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOADA, LOADB, MULT, NORM, PACK} state_t;

    state_t             state_reg, state_next;
    logic [31:0]        a_reg, b_reg;
    logic [47:0]        mcand_reg, prod_reg;
    logic [23:0]        mplier_reg;
    logic [4:0]         count_reg;
    logic signed [9:0]  exp_reg;
    logic [31:0]        res_reg;
    logic               done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.startFP) state_next = LOADA;
            LOADA:   state_next = LOADB;
            LOADB:   state_next = MULT;
            MULT:    if (count_reg == 5'd23) state_next = NORM;
            NORM:    state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand classification; zero-exponent operands (zero/denormal) count as zero.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
    assign a_zero = (a_reg[30:23] == 8'h00);
    assign b_zero = (b_reg[30:23] == 8'h00);
    assign a_inf  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
    assign b_inf  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
    assign a_nan  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
    assign b_nan  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
    assign sign   = a_reg[31] ^ b_reg[31];

    logic signed [9:0] exp_sum;
    assign exp_sum = $signed({2'b00, a_reg[30:23]}) + $signed({2'b00, b_reg[30:23]}) - 10'sd127;

    // After NORM the leading one sits at bit 46; bits below bit 23 are guard/round/sticky.
    logic [23:0]       mant;
    logic              guard, rnd, sticky, round_up;
    logic [24:0]       mant_rnd;
    logic signed [9:0] exp_fin;
    logic [22:0]       frac_fin;
    logic [31:0]       pack_result;

    assign mant     = prod_reg[46:23];
    assign guard    = prod_reg[22];
    assign rnd      = prod_reg[21];
    assign sticky   = |prod_reg[20:0];
    assign round_up = guard & (rnd | sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {24'd0, round_up};
    assign exp_fin  = exp_reg + $signed({9'd0, mant_rnd[24]});
    assign frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

    always_comb begin
        pack_result = {sign, exp_fin[7:0], frac_fin};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            pack_result = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            pack_result = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            pack_result = {sign, 31'd0};
        else if (exp_fin >= 10'sd255)
            pack_result = {sign, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0)
            pack_result = {sign, 31'd0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            exp_reg    <= '0;
            res_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                LOADA: a_reg <= bus.inBus;
                LOADB: begin
                    b_reg      <= bus.inBus;
                    mcand_reg  <= {24'd0, 1'b1, a_reg[22:0]};
                    mplier_reg <= {1'b1, bus.inBus[22:0]};
                    prod_reg   <= '0;
                    count_reg  <= '0;
                end
                MULT: begin
                    if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 5'd1;
                end
                NORM: begin
                    // The bit shifted out is folded into bit 0 so sticky stays exact.
                    exp_reg <= exp_sum + $signed({9'd0, prod_reg[47]});
                    if (prod_reg[47])
                        prod_reg <= {1'b0, prod_reg[47:2], prod_reg[1] | prod_reg[0]};
                end
                PACK: begin
                    res_reg  <= pack_result;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.resBus = res_reg;
    assign bus.doneFP = done_reg;
endmodule

// File: tb/tb_fp_mult2.sv
// Bench for fp_mult2: directed cases, randomized operands against an arithmetic
// reference model, latency/pulse checks, reset abort and start-during-busy.
module tb_fp_mult2;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fp_mult2_if bus();
    fp_mult2 dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, then round-half-even by remainder comparison.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e, sh;
        logic [47:0] p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {s, 31'd0};
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (48'd1 << 47)) begin e++; sh = 24; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 48'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (48'd1 << 24)) begin q = q >> 1; e++; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int   sel;
        logic [31:0] v;
        sel = $urandom_range(0, 15);
        v   = $urandom;
        case (sel)
            0:       v[30:0] = 31'd0;
            1:       v[30:0] = {8'hFF, 23'd0};
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4, 5:    v[30:23] = 8'($urandom_range(1, 24));
            6, 7:    v[30:23] = 8'($urandom_range(230, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        if (sel == 2 && v[22:0] == 23'd0) v[0] = 1'b1;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge following edge N+2.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.startFP = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.startFP = 1'b0;
        bus.inBus   = a;
        @(posedge clk); @(negedge clk);
        bus.inBus   = b;
        @(posedge clk); @(negedge clk);
        bus.inBus   = $urandom;
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat);
        lat = -1;
        res = 'x;
        for (int k = 3; k < 64; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.doneFP) begin
                lat = k;
                res = bus.resBus;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        start_op(a, b);
        wait_done(res, lat);
        check({tag, "_lat"}, 32'(lat), 32'd28);
        check(tag, res, exp);
        @(posedge clk); @(negedge clk);
        check({tag, "_pulse"}, {31'd0, bus.doneFP}, 32'd0);
    endtask

    initial begin
        logic [31:0] res, a, b;
        int          lat, pulses;

        rst = 1'b0;
        bus.startFP = 1'b0;
        bus.inBus   = '0;
        repeat (3) @(negedge clk);
        check("reset_res", bus.resBus, 32'd0);
        check("reset_done", {31'd0, bus.doneFP}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("c1_10.7x2.5", 32'h412B3333, 32'h40200000, 32'h41D60000);
        do_op("c2_1x-3",     32'h3F800000, 32'hC0400000, 32'hC0400000);
        do_op("c2_-1.5sq",   32'hBFC00000, 32'hBFC00000, 32'h40100000);
        do_op("c3_zero",     32'h00000000, 32'h42F60000, 32'h00000000);
        do_op("c3_negzero",  32'h80000000, 32'h3F800000, 32'h80000000);
        do_op("c4_ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000);
        do_op("c4_unf",      32'h00800000, 32'h00800000, 32'h00000000);
        do_op("c5_infx0",    32'h7F800000, 32'h00000000, 32'h7FC00000);
        do_op("c5_infx-2",   32'h7F800000, 32'hC0000000, 32'hFF800000);

        // Back-to-back: new start in the done cycle; resBus holds until its own PACK.
        start_op(32'h40400000, 32'h40400000);
        wait_done(res, lat);
        check("b2b_first", res, 32'h41100000);
        start_op(32'h3FC00000, 32'h40000000);
        check("b2b_hold", bus.resBus, 32'h41100000);
        wait_done(res, lat);
        check("b2b_lat", 32'(lat), 32'd28);
        check("b2b_second", res, 32'h40400000);
        @(negedge clk);

        // Asynchronous reset mid-MULT aborts with no doneFP.
        start_op(32'h412B3333, 32'h40200000);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_res", bus.resBus, 32'd0);
        check("abort_done", {31'd0, bus.doneFP}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (bus.doneFP) pulses++; end
        check("abort_nodone", 32'(pulses), 32'd0);
        do_op("rerun_c1", 32'h412B3333, 32'h40200000, 32'h41D60000);

        // startFP during MULT is ignored: exactly one doneFP.
        start_op(32'hC1200000, 32'h40A00000);
        repeat (5) @(negedge clk);
        bus.startFP = 1'b1;
        @(negedge clk);
        bus.startFP = 1'b0;
        pulses = 0;
        res = 'x;
        repeat (60) begin
            @(negedge clk);
            if (bus.doneFP) begin pulses++; res = bus.resBus; end
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_res", res, 32'hC2480000);

        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            start_op(a, b);
            wait_done(res, lat);
            check($sformatf("rand%0d_lat", i), 32'(lat), 32'd28);
            check($sformatf("rand%0d_%h_%h", i, a, b), res, ref_mul(a, b));
            $display("txn %0d: %h * %h -> %h", i, a, b, res);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
